// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between a producer, the TX FIFO and the UART transmitter.
//   wr_en / wr_data         : producer write strobe and word
//   tx_ready                : transmitter can take a word this cycle
//   send_valid/data_bits_tx : head-of-queue word offered to the transmitter
// master = producer/transmitter side, slave = FIFO side.
interface uart_tx_fifo_if #(
  parameter int WORD_SIZE = 8
);
  logic                 wr_en;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 tx_ready;
  logic                 send_valid;
  logic [WORD_SIZE-1:0] data_bits_tx;

  modport master (
    output wr_en,
    output wr_data,
    output tx_ready,
    input  send_valid,
    input  data_bits_tx
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  tx_ready,
    output send_valid,
    output data_bits_tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte buffer feeding the UART transmitter.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   bus (slave)   : write strobe/data in, send_valid/data_bits_tx out, tx_ready in
//   clr_overflow  : clears the sticky overflow flag
//   count         : stored words, 0..DEPTH
//   empty/full/almost_full : decoded from registered count
//   overflow      : sticky, set when a write is dropped because the FIFO is full
module uart_tx_fifo #(
  parameter int WORD_SIZE    = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_fifo_if.slave            bus,
  input  logic                     clr_overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AFULL_C);

  // A full FIFO drops the write even if a pop frees a slot this same cycle.
  assign push = bus.wr_en && !full;
  assign pop  = bus.send_valid && bus.tx_ready;

  assign bus.send_valid   = !empty;
  assign bus.data_bits_tx = bus.send_valid ? mem[rd_ptr] : '0;

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Set wins over clear when both happen together.
      if (bus.wr_en && full) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_overflow = 1'b0;
  logic [4:0] count;
  logic       empty, full, almost_full, overflow;

  uart_tx_fifo_if #(.WORD_SIZE(8)) bus ();

  uart_tx_fifo #(.WORD_SIZE(8), .DEPTH(16), .AFULL_THRESH(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .clr_overflow (clr_overflow),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int mon_total = 0;
  int mon_bad = 0;

  // Monitor: every accepted transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.send_valid && bus.tx_ready) begin
      mon_total++;
      if (exp_q.size() == 0) begin
        mon_bad++;
        $display("FAIL pop_unexpected: got %02h, expected queue empty", bus.data_bits_tx);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.data_bits_tx !== e) begin
          mon_bad++;
          $display("FAIL pop_data: got %02h, expected %02h", bus.data_bits_tx, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int max_cnt;

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_data  = 8'h00;
    bus.tx_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_send_valid", bus.send_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_data", bus.data_bits_tx, 8'h00);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);

    // Single word
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    bus.wr_en = 1'b0;
    check("single_valid", bus.send_valid, 1);
    check("single_data", bus.data_bits_tx, 8'hA5);
    check("single_count", count, 1);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check("single_count_after", count, 0);
    check("single_valid_after", bus.send_valid, 0);

    // Fill and overflow
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i); exp_q.push_back(8'(i));
      tick();
      check("fill_count", count, 32'(i + 1));
      check("fill_afull", almost_full, (i + 1 >= 12) ? 1 : 0);
      check("fill_full", full, (i + 1 == 16) ? 1 : 0);
    end
    bus.wr_data = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 16);
    check("ovf_head", bus.data_bits_tx, 8'h00);
    bus.tx_ready = 1'b1;
    repeat (16) tick();
    bus.tx_ready = 1'b0;
    check("drain_count", count, 0);
    check("drain_queue_left", exp_q.size(), 0);

    // Concurrent push/pop with wrap
    bus.tx_ready = 1'b1;
    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + i); exp_q.push_back(8'(8'h40 + i));
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    bus.wr_en = 1'b0;
    repeat (3) tick();
    bus.tx_ready = 1'b0;
    check("conc_max_le2", (max_cnt <= 2) ? 1 : 0, 1);
    check("conc_count", count, 0);
    check("conc_queue_left", exp_q.size(), 0);

    // Overflow clear, refill, clear race
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_first", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h80 + i); exp_q.push_back(8'(8'h80 + i));
      tick();
    end
    check("refill_full", full, 1);
    bus.wr_data = 8'hEE; clr_overflow = 1'b1;
    tick();
    bus.wr_en = 1'b0; clr_overflow = 1'b0;
    check("race_overflow", overflow, 1);
    check("race_count", count, 16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_alone", overflow, 0);

    // Write while full with a pop in the same cycle: still dropped
    bus.wr_en = 1'b1; bus.wr_data = 8'hDD; bus.tx_ready = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    check("drop_pop_count", count, 15);
    check("drop_pop_ovf", overflow, 1);
    check("drop_pop_head", bus.data_bits_tx, 8'h81);
    repeat (15) tick();
    bus.tx_ready = 1'b0;
    check("drain2_count", count, 0);
    check("drain2_queue_left", exp_q.size(), 0);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;

    // Reset mid-stream
    for (int i = 0; i < 7; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 + i); exp_q.push_back(8'(8'h10 + i));
      tick();
    end
    bus.wr_en = 1'b0;
    check("mid_count7", count, 7);
    bus.tx_ready = 1'b1; tick();
    bus.tx_ready = 1'b0; tick();
    check("mid_count6", count, 6);
    rst = 1'b1; bus.tx_ready = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0; bus.tx_ready = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_valid", bus.send_valid, 0);
    check("midrst_data", bus.data_bits_tx, 8'h00);
    bus.wr_en = 1'b1; bus.wr_data = 8'h3C; exp_q.push_back(8'h3C);
    tick();
    bus.wr_en = 1'b0;
    check("post_rst_head", bus.data_bits_tx, 8'h3C);
    check("post_rst_count", count, 1);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check("post_rst_empty", empty, 1);
    check("final_queue_left", exp_q.size(), 0);

    tick();
    total = total + mon_total;
    bad = bad + mon_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer sitting directly upstream of the UART transmitter. It decouples a bursty producer (e.g. a control FSM or host interface) from the serial line rate.
- Accepts words on a simple write strobe, stores them in a circular buffer, and drives the transmitter's send_valid/data_bits_tx handshake, popping one word per accepted transfer.
- Reports fill level, full/almost-full status and a sticky overflow flag for dropped writes.

Parameters:
- WORD_SIZE, 8, bits per word; must match the transmitter.
- DEPTH, 16, number of storage entries; power of two, at least 2.
- AFULL_THRESH, 12, almost_full asserts when count is at or above this value; range 1..DEPTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  producer write strobe; one word per cycle while high.
- wr_data  input  WORD_SIZE  word to enqueue; sampled when wr_en=1.
- clr_overflow  input  1  clears the sticky overflow flag.
- tx_ready  input  1  from the transmitter; high when it can accept a word.
- send_valid  output  1  to the transmitter; high while the FIFO holds at least one word.
- data_bits_tx  output  WORD_SIZE  head-of-queue word to the transmitter.
- count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- almost_full  output  1  count>=AFULL_THRESH.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr and count go to 0; overflow goes to 0.
  - Outputs next cycle: send_valid=0, empty=1, full=0, almost_full=0, data_bits_tx=0.
  - Storage contents are don't-care. Reset mid-operation discards all queued words immediately; there is no partial drain.
  - rst has priority over all other inputs in the same cycle.
- Push:
  - A push occurs when wr_en=1 and full=0, evaluated on the registered count.
  - mem[wr_ptr] <= wr_data, then wr_ptr increments modulo DEPTH.
- Dropped write:
  - wr_en=1 while full=1 drops the word, even if a pop occurs in the same cycle.
  - Storage and pointers are unchanged; overflow <= 1.
- Pop:
  - A pop occurs when send_valid=1 and tx_ready=1 in the same cycle.
  - rd_ptr increments modulo DEPTH.
- send_valid and data_bits_tx:
  - send_valid = (count != 0), derived from registered state, with no combinational path from tx_ready or wr_en.
  - data_bits_tx = mem[rd_ptr] while send_valid=1, else 0.
  - Held stable while send_valid=1 and tx_ready=0.
- count update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
  - neither: unchanged.
- Simultaneous push and pop is only possible when 0 < count < DEPTH. With count=0, send_valid=0 so no pop can occur.
- Latency:
  - A word written into an empty FIFO at edge N gives send_valid=1 after edge N, so the transmitter can accept it in the following cycle.
  - A popped word leaves the head and the next word is presented one cycle after the accepting edge.
- Ordering: strict FIFO order; pointers wrap from DEPTH-1 to 0 with no gap or duplication.
- Status flags: empty, full and almost_full are pure functions of registered count.
- Overflow clear:
  - clr_overflow=1 clears overflow at the next edge.
  - If a drop occurs in the same cycle as clr_overflow, set wins and overflow stays 1.
- The FIFO has no knowledge of baud timing; it relies solely on tx_ready from the transmitter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> send_valid=0, empty=1, count=0, overflow=0, data_bits_tx=8'h00.
- Single word: write 8'hA5 with tx_ready=0 -> next cycle send_valid=1, data_bits_tx=8'hA5, count=1. Raise tx_ready for one cycle -> count=0, send_valid=0.
- Fill and overflow (DEPTH=16, tx_ready=0):
  - Write 8'h00..8'h0F -> count=16, full=1; almost_full=1 from count=12.
  - A 17th write of 8'hFF -> overflow=1, count stays 16.
  - Drain -> output sequence 8'h00..8'h0F, with no 8'hFF.
- Concurrent push/pop and wrap:
  - Hold tx_ready=1 and write 40 incrementing bytes back-to-back.
  - Result: count never exceeds 2, pointers wrap at least twice, and all 40 bytes are received in order.
- Overflow clear race:
  - With full=1, assert wr_en and clr_overflow in the same cycle -> overflow remains 1.
  - Next cycle, clr_overflow alone -> overflow=0.
- Reset mid-stream: with count=7 and tx_ready toggling, assert rst for 1 cycle -> next cycle count=0 and send_valid=0. A subsequent write of 8'h3C is the first word presented.
